// File: rtl/reg_pipe_pkg.sv
// -----------------------------------------------------------------------------
// reg_pipe_pkg
// Shared constants and helpers for the reg_pipe register pipeline.
//   DEF_WIDTH     : default data bits per stage
//   DEF_DEPTH     : default number of register stages (legal 1..64)
//   DEF_RESET_VAL : default data value loaded into every stage on reset
//   cnt_w(depth)  : bit width needed to hold a count of 0..depth valid words
// -----------------------------------------------------------------------------
package reg_pipe_pkg;

  localparam int DEF_WIDTH     = 1;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_RESET_VAL = 0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : reg_pipe_pkg

// File: rtl/dff_stage.sv
// -----------------------------------------------------------------------------
// dff_stage
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset (data <- RESET_VAL, valid <- 0)
//   en        : 1 loads data/valid_in, 0 holds
//   flush     : synchronous invalidate; clears valid, keeps data, beats en
//   data      : data from the previous stage (or the pipe input)
//   valid_in  : valid from the previous stage (or the pipe input)
//   q         : registered data
//   valid_out : registered valid
// -----------------------------------------------------------------------------
module dff_stage #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  input  logic             valid_in,
  output logic [WIDTH-1:0] q,
  output logic             valid_out
);

  // NOTE: non-blocking assignments so each stage samples its neighbour's
  // pre-edge value; blocking here would let a word ripple through the chain.
  // NOTE: the data register is reset as well, because q must read RESET_VAL
  // while reset is held, not just be marked invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q         <= RESET_VAL;
      valid_out <= 1'b0;
    end else if (flush) begin
      valid_out <= 1'b0;   // data deliberately held
    end else if (en) begin
      q         <= data;
      valid_out <= valid_in;
    end
  end

endmodule : dff_stage

// File: rtl/reg_pipe.sv
// -----------------------------------------------------------------------------
// reg_pipe
// DEPTH-stage enabled register pipeline with per-stage valid bits, a
// synchronous flush and a registered occupancy count.
// Parameters: WIDTH (data bits), DEPTH (stages, 1..64), RESET_VAL (reset data)
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   en        : 1 shifts the pipe one stage, 0 holds everything
//   flush     : synchronous invalidate of all stages (overrides en)
//   data      : stage-0 data input
//   valid_in  : qualifies data
//   q         : last-stage data (don't-care while valid_out = 0)
//   valid_out : last-stage valid
//   count     : number of valid stages (popcount of the valid bits)
//   empty     : count == 0
//   full      : count == DEPTH
// -----------------------------------------------------------------------------
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          data,
  input  logic                      valid_in,
  output logic [WIDTH-1:0]          q,
  output logic                      valid_out,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      empty,
  output logic                      full
);

  localparam int CW = cnt_w(DEPTH);

  // Element 0 is the pipe input; element i+1 is the output of stage i.
  logic [WIDTH-1:0] d_chain [DEPTH+1];
  logic             v_chain [DEPTH+1];

  assign d_chain[0] = data;
  assign v_chain[0] = valid_in;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .data      (d_chain[i]),
      .valid_in  (v_chain[i]),
      .q         (d_chain[i+1]),
      .valid_out (v_chain[i+1])
    );
  end

  // Straight from the last stage's registers: no input-to-output path.
  assign q         = d_chain[DEPTH];
  assign valid_out = v_chain[DEPTH];

  // Tracked incrementally instead of a popcount tree. When the pipe is full
  // and a valid word enters, the last-stage word retires in the same edge, so
  // the sum never truly exceeds DEPTH; any transient carry out of CW bits
  // cancels in modular arithmetic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(valid_in) - CW'(v_chain[DEPTH]);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule : reg_pipe

// File: tb/tb_reg_pipe.sv
// -----------------------------------------------------------------------------
// tb_reg_pipe
// Directed-vector bench for reg_pipe with WIDTH=8, DEPTH=4, RESET_VAL=8'h00.
// Expected values are hand-computed per edge.
// -----------------------------------------------------------------------------
module tb_reg_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             flush;
  logic [WIDTH-1:0] data;
  logic             valid_in;
  logic [WIDTH-1:0] q;
  logic             valid_out;
  logic [2:0]       count;
  logic             empty;
  logic             full;

  int tests_run = 0;
  int tests_failed = 0;

  reg_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .data      (data),
    .valid_in  (valid_in),
    .q         (q),
    .valid_out (valid_out),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one set of inputs, take one rising edge, then check outputs 1 time
  // unit later. q is only checked when chk_q is set.
  task automatic cyc(input string tag, input logic e, input logic f,
                     input logic vi, input logic [7:0] d,
                     input logic evo, input logic chk_q, input logic [7:0] eq,
                     input int ecnt);
    en       = e;
    flush    = f;
    valid_in = vi;
    data     = d;
    @(posedge clk);
    #1;
    check({tag, ".valid_out"}, 32'(valid_out), 32'(evo));
    check({tag, ".count"},     32'(count),     32'(ecnt));
    check({tag, ".empty"},     32'(empty),     32'(ecnt == 0));
    check({tag, ".full"},      32'(full),      32'(ecnt == DEPTH));
    if (chk_q) check({tag, ".q"}, 32'(q), 32'(eq));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".q"},         32'(q),         32'h00);
    check({tag, ".valid_out"}, 32'(valid_out), 32'h0);
    check({tag, ".count"},     32'(count),     32'h0);
    check({tag, ".empty"},     32'(empty),     32'h1);
    check({tag, ".full"},      32'(full),      32'h0);
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b0;
    data     = 8'h00;
    #2;
    check_reset_state("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single word: emerges on the 4th enabled edge for exactly one cycle.
    cyc("single.e1", 1, 0, 1, 8'hA1, 0, 0, 8'h00, 1);
    cyc("single.e2", 1, 0, 0, 8'h00, 0, 0, 8'h00, 1);
    cyc("single.e3", 1, 0, 0, 8'h00, 0, 0, 8'h00, 1);
    cyc("single.e4", 1, 0, 0, 8'h00, 1, 1, 8'hA1, 1);
    cyc("single.e5", 1, 0, 0, 8'h00, 0, 0, 8'h00, 0);

    // Back-to-back fill; full pipe accepting a word keeps count at DEPTH.
    cyc("fill.e1", 1, 0, 1, 8'hA1, 0, 0, 8'h00, 1);
    cyc("fill.e2", 1, 0, 1, 8'hA2, 0, 0, 8'h00, 2);
    cyc("fill.e3", 1, 0, 1, 8'hA3, 0, 0, 8'h00, 3);
    cyc("fill.e4", 1, 0, 1, 8'hA4, 1, 1, 8'hA1, 4);
    cyc("fill.e5", 1, 0, 1, 8'hA5, 1, 1, 8'hA2, 4);
    cyc("fill.e6", 1, 0, 0, 8'h00, 1, 1, 8'hA3, 3);
    cyc("fill.e7", 1, 0, 0, 8'h00, 1, 1, 8'hA4, 2);
    cyc("fill.e8", 1, 0, 0, 8'h00, 1, 1, 8'hA5, 1);
    cyc("fill.e9", 1, 0, 0, 8'h00, 0, 0, 8'h00, 0);

    // Stall: 3 en=0 cycles with 2 words in flight delay them by 3 cycles.
    // The last stage holds the invalid 8'h00 shifted in by the drain above.
    cyc("stall.e1", 1, 0, 1, 8'hB1, 0, 1, 8'h00, 1);
    cyc("stall.e2", 1, 0, 1, 8'hB2, 0, 1, 8'h00, 2);
    cyc("stall.h1", 0, 0, 1, 8'hEE, 0, 1, 8'h00, 2);
    cyc("stall.h2", 0, 0, 1, 8'hEE, 0, 1, 8'h00, 2);
    cyc("stall.h3", 0, 0, 1, 8'hEE, 0, 1, 8'h00, 2);
    cyc("stall.e3", 1, 0, 0, 8'h00, 0, 0, 8'h00, 2);
    cyc("stall.e4", 1, 0, 0, 8'h00, 1, 1, 8'hB1, 2);
    cyc("stall.e5", 1, 0, 0, 8'h00, 1, 1, 8'hB2, 1);
    cyc("stall.e6", 1, 0, 0, 8'h00, 0, 0, 8'h00, 0);

    // Flush with 3 in flight; the word offered during flush is dropped.
    cyc("flush.e1", 1, 0, 1, 8'hC1, 0, 0, 8'h00, 1);
    cyc("flush.e2", 1, 0, 1, 8'hC2, 0, 0, 8'h00, 2);
    cyc("flush.e3", 1, 0, 1, 8'hC3, 0, 0, 8'h00, 3);
    cyc("flush.f",  1, 1, 1, 8'hFF, 0, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH + 1; i++)
      cyc($sformatf("flush.drain%0d", i), 1, 0, 0, 8'h00, 0, 0, 8'h00, 0);

    // Reset mid-stream, asserted between edges and held across one edge.
    cyc("rst.e1", 1, 0, 1, 8'hD1, 0, 0, 8'h00, 1);
    cyc("rst.e2", 1, 0, 1, 8'hD2, 0, 0, 8'h00, 2);
    #2 reset = 1'b0;
    #1 check_reset_state("rst.async");
    en       = 1'b1;
    valid_in = 1'b1;
    data     = 8'hD3;
    @(posedge clk);
    #1 check_reset_state("rst.held");
    reset = 1'b1;
    cyc("rst.n1", 1, 0, 1, 8'h5C, 0, 0, 8'h00, 1);
    cyc("rst.n2", 1, 0, 0, 8'h00, 0, 0, 8'h00, 1);
    cyc("rst.n3", 1, 0, 0, 8'h00, 0, 0, 8'h00, 1);
    cyc("rst.n4", 1, 0, 0, 8'h00, 1, 1, 8'h5C, 1);
    cyc("rst.n5", 1, 0, 0, 8'h00, 0, 0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_reg_pipe

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: data bits per stage.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of register stages; legal range 1..64.
REQ-003 The block SHALL have parameter RESET_VAL, default 0 (WIDTH bits): value loaded into every data stage on reset.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: advance strobe; 1 shifts the pipe, 0 holds it.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous invalidate of all stages.
REQ-008 The block SHALL have port data, input, WIDTH bits: stage-0 data input.
REQ-009 The block SHALL have port valid_in, input, 1 bit: qualifies data.
REQ-010 The block SHALL have port q, output, WIDTH bits: last-stage data.
REQ-011 The block SHALL have port valid_out, output, 1 bit: last-stage valid.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH+1) bits: number of valid stages.
REQ-013 The block SHALL have ports empty and full, outputs, 1 bit each: count==0 and count==DEPTH.

Function
REQ-014 Each stage i SHALL hold a data register d[i] and a valid bit v[i].
REQ-015 On a clk edge with flush=0 and en=1, the block SHALL load d[0]<=data, v[0]<=valid_in, and d[i]<=d[i-1], v[i]<=v[i-1] for i>=1.
REQ-016 On a clk edge with flush=0 and en=0, all d, v and count SHALL hold.
REQ-017 On a clk edge with flush=1, all v SHALL clear to 0, count SHALL clear to 0, and d SHALL hold; flush overrides en, and valid_in is dropped.
REQ-018 q SHALL equal d[DEPTH-1] and valid_out SHALL equal v[DEPTH-1], driven directly from registers with no combinational path from inputs.
REQ-019 Latency SHALL be exactly DEPTH en=1 edges from capture to valid_out=1; en=0 cycles stretch it one-for-one.
REQ-020 count SHALL update registered on an en=1 edge as count + valid_in - v[DEPTH-1], and SHALL always equal the popcount of v.
REQ-021 count SHALL never exceed DEPTH; when full=1 and en=1, accepting a new valid word SHALL retire the last-stage word in the same edge, leaving count unchanged.
REQ-022 Invalid words (valid_in=0) SHALL still shift data, and q SHALL be don't-care while valid_out=0.
REQ-023 DEPTH=1 SHALL behave as a single enabled DFF with valid bit, with count width 1.

Reset
REQ-024 reset=0 SHALL immediately, without a clk edge, force all d to RESET_VAL, all v to 0 and count to 0, giving q=RESET_VAL, valid_out=0, empty=1, full=0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight words, and no word SHALL emerge after release.
REQ-026 Reset release SHALL be synchronised externally, and the first edge after release SHALL behave per REQ-015 to REQ-017.

Structure
REQ-027 Package reg_pipe_pkg SHALL hold the default constants (DEF_WIDTH, DEF_DEPTH, DEF_RESET_VAL) and a count-width function cnt_w(depth)=$clog2(depth+1).
REQ-028 One sub-module, dff_stage (WIDTH-bit data plus valid, en, flush, asynchronous active-low reset), SHALL be instantiated DEPTH times via generate, and count logic SHALL live in reg_pipe.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=8'h00)
REQ-029 reset driven 0 between edges -> q=8'h00, valid_out=0, count=0 and empty=1 before the next edge.
REQ-030 en=1, a single word data=8'hA1 with valid_in=1, then valid_in=0 -> valid_out=1 with q=8'hA1 on the 4th edge, for exactly one cycle.
REQ-031 en=1, words 8'hA1..8'hA4 back-to-back, then 8'hA5 -> count=4 and full=1 after the 4th edge; count stays 4 while 8'hA1 exits; outputs appear in order.
REQ-032 en=0 for 3 cycles with 2 words in flight -> q, valid_out and count stable; on resume, the words emerge 3 cycles later than nominal.
REQ-033 flush=1, en=1, valid_in=1, data=8'hFF with 3 words in flight -> count=0 and valid_out=0 after the edge, and 8'hFF never appears valid.
REQ-034 reset pulsed low mid-stream, then a new word 8'h5C after release -> no stale word emerges, and 8'h5C appears valid 4 edges after capture.
